prog_loader: RTL and testbench

//  Boot-time program loader sitting directly upstream of instructionMem.

---
 rtl/prog_loader_if.sv | 32 +++
 rtl/prog_loader.sv | 155 +++++++++++++++
 tb/tb_prog_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Boot loader bus bundle: byte stream in, instruction-memory write/read port,
// plus the start/status handshake. master = the loader, slave = its environment.
interface prog_loader_if #(
    parameter int CNT_W = 9
);
    logic             start;
    logic [CNT_W-1:0] num_words;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      writeAddr;
    logic [31:0]      writeData;
    logic             wr;
    logic [31:0]      readAddr;
    logic [31:0]      readData;
    logic             busy;
    logic             done;
    logic             err;
    logic             cpu_hold;

    modport master (
        input  start, num_words, in_byte, in_valid, readData,
        output in_ready, writeAddr, writeData, wr, readAddr,
               busy, done, err, cpu_hold
    );

    modport slave (
        output start, num_words, in_byte, in_valid, readData,
        input  in_ready, writeAddr, writeData, wr, readAddr,
               busy, done, err, cpu_hold
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: packs a little-endian byte stream into 32-bit
// words, writes them to consecutive instruction-memory addresses, reads the
// image back and compares XOR checksums. The CPU stays held in reset until a
// clean, verified image is in place.
module prog_loader #(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 9
) (
    input  logic            clk,
    input  logic            reset_n,
    prog_loader_if.master   bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSEMBLE = 3'd1,
        ST_WRITE    = 3'd2,
        ST_VERIFY   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] idx_r;
    logic [1:0]       lane_r;
    logic [23:0]      word_r;   // first three bytes of the word in progress
    logic [31:0]      wsum_r;
    logic [31:0]      rsum_r;

    logic [CNT_W-1:0] idx_inc_s;
    logic             last_s;
    logic [31:0]      addr_s;
    logic [31:0]      addr_inc_s;
    logic [31:0]      packed_s;
    logic [31:0]      rsum_next_s;
    logic             accept_s;

    // Derived values shared by the sequencing logic.
    always_comb begin
        idx_inc_s   = idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
        last_s      = (idx_inc_s == count_r);
        addr_s      = {{(32-CNT_W){1'b0}}, idx_r};
        addr_inc_s  = {{(32-CNT_W){1'b0}}, idx_inc_s};
        packed_s    = {bus.in_byte, word_r};
        rsum_next_s = rsum_r ^ bus.readData;
        accept_s    = bus.in_valid & bus.in_ready;
    end

    // Loader state machine; every output is a register updated on the
    // transition into the state that owns it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            count_r       <= {CNT_W{1'b0}};
            idx_r         <= {CNT_W{1'b0}};
            lane_r        <= 2'd0;
            word_r        <= 24'd0;
            wsum_r        <= 32'd0;
            rsum_r        <= 32'd0;
            bus.in_ready  <= 1'b0;
            bus.wr        <= 1'b0;
            bus.writeAddr <= 32'd0;
            bus.writeData <= 32'd0;
            bus.readAddr  <= 32'd0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.cpu_hold  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        count_r <= bus.num_words;
                        idx_r   <= {CNT_W{1'b0}};
                        lane_r  <= 2'd0;
                        word_r  <= 24'd0;
                        wsum_r  <= 32'd0;
                        rsum_r  <= 32'd0;
                        if (bus.num_words == {CNT_W{1'b0}}) begin
                            // Empty image is trivially valid: release the CPU.
                            state_r      <= ST_DONE;
                            bus.done     <= 1'b1;
                            bus.err      <= 1'b0;
                            bus.cpu_hold <= 1'b0;
                        end else if (bus.num_words > CNT_W'(MAX_WORDS)) begin
                            // Image cannot fit: report error, keep CPU held.
                            state_r      <= ST_DONE;
                            bus.done     <= 1'b1;
                            bus.err      <= 1'b1;
                            bus.cpu_hold <= 1'b1;
                        end else begin
                            state_r      <= ST_ASSEMBLE;
                            bus.done     <= 1'b0;
                            bus.err      <= 1'b0;
                            bus.cpu_hold <= 1'b1;
                            bus.busy     <= 1'b1;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                ST_ASSEMBLE: begin
                    if (accept_s) begin
                        lane_r <= lane_r + 2'd1;
                        case (lane_r)
                            2'd0: word_r[7:0]   <= bus.in_byte;
                            2'd1: word_r[15:8]  <= bus.in_byte;
                            2'd2: word_r[23:16] <= bus.in_byte;
                            2'd3: begin
                                state_r       <= ST_WRITE;
                                bus.in_ready  <= 1'b0;
                                bus.wr        <= 1'b1;
                                bus.writeAddr <= addr_s;
                                bus.writeData <= packed_s;
                            end
                            default: lane_r <= 2'd0;
                        endcase
                    end
                end
                ST_WRITE: begin
                    bus.wr <= 1'b0;
                    wsum_r <= wsum_r ^ bus.writeData;
                    if (last_s) begin
                        state_r      <= ST_VERIFY;
                        idx_r        <= {CNT_W{1'b0}};
                        bus.readAddr <= 32'd0;
                    end else begin
                        state_r      <= ST_ASSEMBLE;
                        idx_r        <= idx_inc_s;
                        bus.in_ready <= 1'b1;
                    end
                end
                ST_VERIFY: begin
                    rsum_r <= rsum_next_s;
                    if (last_s) begin
                        state_r      <= ST_DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.err      <= (rsum_next_s != wsum_r);
                        bus.cpu_hold <= (rsum_next_s != wsum_r);
                    end else begin
                        idx_r        <= idx_inc_s;
                        bus.readAddr <= addr_inc_s;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    bus.in_ready <= 1'b0;
                    bus.wr       <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: loads push expected memory writes and the
// expected done/err/cpu_hold outcome; a monitor pops and compares them.
module tb_prog_loader;

    localparam int MAX_WORDS = 256;
    localparam int CNT_W     = 9;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset_n;

    prog_loader_if #(.CNT_W(CNT_W)) bus ();

    prog_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          checks;
    int          failures;
    wr_t         wq[$];
    logic [1:0]  dq[$];          // {err, cpu_hold} expected at done
    logic [7:0]  stim_q[$];
    logic [31:0] mem [MAX_WORDS];
    int          corrupt_idx;
    bit          wr_prev;
    bit          done_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: synchronous write, combinational read with an
    // optional single-word bit-0 corruption on readback.
    always @(posedge clk) begin
        if (bus.wr) mem[bus.writeAddr[7:0]] <= bus.writeData;
    end
    assign bus.readData = mem[bus.readAddr[7:0]] ^
        (((corrupt_idx >= 0) && (bus.readAddr == 32'(corrupt_idx))) ? 32'd1 : 32'd0);

    // Monitor: compares every write and every completed load with the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        logic [1:0] d;
        if (reset_n) begin
            if (bus.wr) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_wr addr=%h data=%h", bus.writeAddr, bus.writeData);
                end else begin
                    e = wq.pop_front();
                    checks++;
                    if (bus.writeAddr != e.addr || bus.writeData != e.data) begin
                        failures++;
                        $display("FAIL write got=%h:%h exp=%h:%h", bus.writeAddr, bus.writeData, e.addr, e.data);
                    end
                end
                checks++;
                if (bus.in_ready !== 1'b0 || wr_prev) begin
                    failures++;
                    $display("FAIL wr_cycle in_ready=%b wr_prev=%b exp 0/0", bus.in_ready, wr_prev);
                end
            end
            if (bus.done && !done_prev) begin
                checks++;
                if (dq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done err=%b", bus.err);
                end else begin
                    d = dq.pop_front();
                    if ({bus.err, bus.cpu_hold, bus.busy} != {d, 1'b0}) begin
                        failures++;
                        $display("FAIL done_status got err/hold/busy=%b%b%b exp=%b0", bus.err, bus.cpu_hold, bus.busy, d);
                    end
                end
            end
        end
        wr_prev   = bus.wr;
        done_prev = bus.done;
    end

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({bus.in_ready, bus.wr, bus.busy, bus.done, bus.err, bus.cpu_hold} != 6'b000001 ||
            bus.writeAddr != 32'd0 || bus.writeData != 32'd0 || bus.readAddr != 32'd0) begin
            failures++;
            $display("FAIL %s rdy/wr/busy/done/err/hold=%b%b%b%b%b%b exp=000001 wa=%h wd=%h ra=%h exp 0",
                     name, bus.in_ready, bus.wr, bus.busy, bus.done, bus.err, bus.cpu_hold,
                     bus.writeAddr, bus.writeData, bus.readAddr);
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.num_words = CNT_W'(n);
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    // Runs one load. Bytes come from stim_q. corrupt < 0 means clean readback.
    task automatic run_load(input int n, input int corrupt, input bit toggle,
                            input bit mid_start, input int abort_after);
        int nb;
        int acc;
        int cyc;
        bit ok;
        bit hit;
        logic [31:0] w;
        logic [31:0] xs;
        logic [31:0] xr;
        wr_t e;
        corrupt_idx = corrupt;
        if (n < 1 || n > MAX_WORDS) begin
            pulse_start(n);
            checks++;
            if ({bus.done, bus.busy, bus.err, bus.cpu_hold} != {2'b10, (n != 0), (n != 0)}) begin
                failures++;
                $display("FAIL bad_count n=%0d done/busy/err/hold=%b%b%b%b", n, bus.done, bus.busy, bus.err, bus.cpu_hold);
            end
            repeat (3) @(posedge clk);
            return;
        end
        nb = 4 * n;
        xs = 32'd0;
        xr = 32'd0;
        for (int k = 0; k < n; k++) begin
            w = {stim_q[4*k+3], stim_q[4*k+2], stim_q[4*k+1], stim_q[4*k]};
            e.addr = 32'(k);
            e.data = w;
            wq.push_back(e);
            xs ^= w;
            xr ^= (k == corrupt) ? (w ^ 32'd1) : w;
        end
        if (abort_after < 0) dq.push_back({(xs != xr), (xs != xr)});
        pulse_start(n);
        acc = 0;
        cyc = 0;
        while (acc < nb && cyc < 10 * nb + 50) begin
            bus.in_byte  = stim_q[acc];
            bus.in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            bus.start    = (mid_start && cyc == 3);
            bus.num_words = mid_start ? CNT_W'(1) : CNT_W'(n);
            @(negedge clk);
            hit = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (hit) acc++;
            cyc++;
            if (abort_after >= 0 && acc == abort_after) begin
                reset_n = 1'b0;
                #1;
                check_reset_outputs("async_reset");
                bus.in_valid = 1'b0;
                bus.start    = 1'b0;
                wq.delete();
                @(posedge clk); #1;
                reset_n = 1'b1;
                return;
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        checks++;
        if (acc != nb) begin
            failures++;
            $display("FAIL feed_timeout accepted=%0d exp=%0d", acc, nb);
        end
        ok = 1'b0;
        for (int c = 0; c < 4 * n + 40 && !ok; c++) begin
            @(negedge clk);
            ok = bus.done;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL done_timeout n=%0d done=%b exp=1", n, bus.done);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int k = 0; k < 4 * n; k++) stim_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic fill_directed();
        logic [7:0] b [12];
        b = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h11, 8'h22, 8'h33, 8'h44,
              8'hEF, 8'hBE, 8'hAD, 8'hDE};
        stim_q.delete();
        for (int k = 0; k < 12; k++) stim_q.push_back(b[k]);
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        corrupt_idx = -1;
        wr_prev = 1'b0;
        done_prev = 1'b0;
        for (int k = 0; k < MAX_WORDS; k++) mem[k] = 32'd0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.num_words = '0;
        bus.in_byte = 8'd0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset_n = 1'b1;

        // Directed image, streaming and with in_valid toggling.
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 3; k++) mem[k] = 32'd0;
            fill_directed();
            run_load(3, -1, t[0], 1'b0, -1);
            checks++;
            if (mem[0] != 32'h13000000 || mem[1] != 32'h44332211 || mem[2] != 32'hDEADBEEF ||
                bus.cpu_hold != 1'b0 || bus.err != 1'b0) begin
                failures++;
                $display("FAIL directed_image t=%0d mem=%h %h %h hold=%b err=%b exp 13000000 44332211 deadbeef 0 0",
                         t, mem[0], mem[1], mem[2], bus.cpu_hold, bus.err);
            end
        end

        // Count boundaries.
        run_load(0, -1, 1'b0, 1'b0, -1);
        run_load(257, -1, 1'b0, 1'b0, -1);
        run_load(0, -1, 1'b0, 1'b0, -1);

        // Corrupted readback of word 1.
        fill_directed();
        run_load(3, 1, 1'b0, 1'b0, -1);

        // Reset after 6 bytes of a 4-word load, then a fresh 2-word load.
        fill_random(4);
        run_load(4, -1, 1'b0, 1'b0, 6);
        fill_random(2);
        run_load(2, -1, 1'b0, 1'b0, -1);

        // start pulsed mid-assembly is ignored.
        fill_random(3);
        run_load(3, -1, 1'b0, 1'b1, -1);

        // Full-capacity image.
        fill_random(MAX_WORDS);
        run_load(MAX_WORDS, -1, 1'b0, 1'b0, -1);

        // Randomized loads.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 12);
            fill_random(n);
            run_load(n, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                     bit'($urandom_range(0, 1)), 1'b0, -1);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain writes_left=%0d dones_left=%0d exp 0 0", wq.size(), dq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
